// File: rtl/mem_port_arbiter_if.sv
// Signal bundle around the shared data-RAM port: CPU requester, host loader and RAM side.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              host_lock;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              owner;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        input  host_lock,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output owner, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        output host_lock,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  owner, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port data-RAM arbiter between CPU and host loader: one access in flight,
// IDLE -> ACCESS -> WAIT -> RESP sequencing, host priority with a CPU starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int HOST_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam int STRK_W = $clog2(HOST_MAX + 1);
    localparam int CNT_W  = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [STRK_W-1:0] STRK_MAX  = STRK_W'(HOST_MAX);
    localparam logic [CNT_W-1:0]  WAIT_LOAD = (RD_LAT > 1) ? CNT_W'(RD_LAT - 2) : {CNT_W{1'b0}};

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [STRK_W-1:0] r_streak;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_host_rdata;

    logic              w_cpu_elig;
    logic              w_any_req;
    logic              w_host_wins;
    logic [STRK_W-1:0] w_next_streak;
    logic              w_resp_rd;

    // Grant decision: host wins unless the CPU has already waited HOST_MAX host grants.
    always_comb begin
        w_cpu_elig  = bus.cpu_req & ~bus.host_lock;
        w_any_req   = bus.host_req | w_cpu_elig;
        w_host_wins = bus.host_req & ~(w_cpu_elig & (r_streak == STRK_MAX));
        if (w_host_wins && w_cpu_elig) begin
            if (r_streak == STRK_MAX) begin
                w_next_streak = STRK_MAX;
            end else begin
                w_next_streak = r_streak + STRK_W'(1);
            end
        end else begin
            w_next_streak = {STRK_W{1'b0}};
        end
    end

    // Sequencer: latch the winner's request at grant, then step through the RAM access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_wait_cnt   <= {CNT_W{1'b0}};
            r_streak     <= {STRK_W{1'b0}};
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= {ADDR_W{1'b0}};
            r_wdata      <= {DATA_W{1'b0}};
            r_cpu_rdata  <= {DATA_W{1'b0}};
            r_host_rdata <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state  <= ST_ACCESS;
                        r_owner  <= w_host_wins;
                        r_streak <= w_next_streak;
                        if (w_host_wins) begin
                            r_we    <= bus.host_we;
                            r_addr  <= bus.host_addr;
                            r_wdata <= bus.host_wdata;
                        end else begin
                            r_we    <= bus.cpu_we;
                            r_addr  <= bus.cpu_addr;
                            r_wdata <= bus.cpu_wdata;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (RD_LAT > 1) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= WAIT_LOAD;
                    end else begin
                        r_state <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == {CNT_W{1'b0}}) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    if (!r_we) begin
                        if (r_owner) begin
                            r_host_rdata <= bus.mem_rdata;
                        end else begin
                            r_cpu_rdata <= bus.mem_rdata;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM data arrives in RESP, so read data bypasses to the owner while its ack is high.
    assign w_resp_rd      = (r_state == ST_RESP) & ~r_we;
    assign bus.cpu_rdata  = (w_resp_rd & ~r_owner) ? bus.mem_rdata : r_cpu_rdata;
    assign bus.host_rdata = (w_resp_rd & r_owner) ? bus.mem_rdata : r_host_rdata;
    assign bus.cpu_ack    = (r_state == ST_RESP) & ~r_owner;
    assign bus.host_ack   = (r_state == ST_RESP) & r_owner;
    assign bus.mem_en     = (r_state == ST_ACCESS);
    assign bus.mem_we     = (r_state == ST_ACCESS) & r_we;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.owner      = r_owner;
    assign bus.busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model on a RD_LAT=1 instance with random
// traffic and directed scenarios, plus a RD_LAT=3 instance for latency checks.
module tb_mem_port_arbiter;
    localparam int L0   = 1;
    localparam int L1   = 3;
    localparam int HMAX = 4;

    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   cmp_en   = 1'b0;

    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(L0), .HOST_MAX(HMAX)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0));
    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(L1), .HOST_MAX(HMAX)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [7:0] init_val(input logic [7:0] a);
        if (a == 8'h10) return 8'hA5;
        return a * 8'd29 + 8'd7;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM for lane 0: one-cycle read latency
    logic [7:0] ram0 [256];
    logic [7:0] rd0;
    bit         ram0_ok = 1'b0;
    always @(posedge clock) begin
        if (!ram0_ok) begin
            for (int i = 0; i < 256; i++) ram0[i] <= init_val(8'(i));
            ram0_ok <= 1'b1;
        end else if (bus0.mem_en) begin
            if (bus0.mem_we) ram0[bus0.mem_addr] <= bus0.mem_wdata;
            else             rd0 <= ram0[bus0.mem_addr];
        end
    end
    assign bus0.mem_rdata = rd0;

    // RAM for lane 1: three-cycle read pipeline
    logic [7:0] ram1 [256];
    logic [7:0] p1 [3];
    bit         ram1_ok = 1'b0;
    always @(posedge clock) begin
        if (!ram1_ok) begin
            for (int i = 0; i < 256; i++) ram1[i] <= init_val(8'(i));
            ram1_ok <= 1'b1;
        end else if (bus1.mem_en && bus1.mem_we) begin
            ram1[bus1.mem_addr] <= bus1.mem_wdata;
        end
        p1[0] <= (bus1.mem_en && !bus1.mem_we) ? ram1[bus1.mem_addr] : 8'h00;
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign bus1.mem_rdata = p1[2];

    // Transaction-level model of lane 0: phase = cycles since grant, 0 when idle.
    int         m_phase, m_streak;
    bit         m_owner, m_we;
    logic [7:0] m_addr, m_wdata, m_cpu_rd, m_host_rd;
    logic [7:0] m_mem [256];
    bit         m_written [256];
    initial begin
        bit cpu_ok, host_pick;
        logic [7:0] rd;
        m_phase = 0; m_streak = 0; m_owner = 1'b0; m_we = 1'b0;
        m_addr = 8'h00; m_wdata = 8'h00; m_cpu_rd = 8'h00; m_host_rd = 8'h00;
        for (int i = 0; i < 256; i++) m_written[i] = 1'b0;
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_phase = 0; m_streak = 0; m_owner = 1'b0; m_we = 1'b0;
                m_addr = 8'h00; m_wdata = 8'h00; m_cpu_rd = 8'h00; m_host_rd = 8'h00;
            end else if (m_phase == 0) begin
                cpu_ok = bus0.cpu_req && !bus0.host_lock;
                if (bus0.host_req || cpu_ok) begin
                    host_pick = bus0.host_req && !(cpu_ok && m_streak >= HMAX);
                    if (host_pick && cpu_ok) m_streak = (m_streak + 1 > HMAX) ? HMAX : m_streak + 1;
                    else                     m_streak = 0;
                    m_owner = host_pick;
                    m_we    = host_pick ? bus0.host_we    : bus0.cpu_we;
                    m_addr  = host_pick ? bus0.host_addr  : bus0.cpu_addr;
                    m_wdata = host_pick ? bus0.host_wdata : bus0.cpu_wdata;
                    m_phase = 1;
                end
            end else if (m_phase == L0 + 1) begin
                m_phase = 0;
            end else begin
                if (m_phase == 1 && m_we) begin
                    m_mem[m_addr] = m_wdata;
                    m_written[m_addr] = 1'b1;
                end
                m_phase++;
                if (m_phase == L0 + 1 && !m_we) begin
                    rd = m_written[m_addr] ? m_mem[m_addr] : init_val(m_addr);
                    if (m_owner) m_host_rd = rd;
                    else         m_cpu_rd  = rd;
                end
            end
        end
    end

    // Every-cycle comparison of lane 0 against the model
    initial begin
        forever begin
            @(negedge clock);
            if (cmp_en) begin
                chk("busy",       int'(bus0.busy),       int'(m_phase != 0));
                chk("mem_en",     int'(bus0.mem_en),     int'(m_phase == 1));
                chk("mem_we",     int'(bus0.mem_we),     int'(m_phase == 1 && m_we));
                chk("cpu_ack",    int'(bus0.cpu_ack),    int'(m_phase == L0 + 1 && !m_owner));
                chk("host_ack",   int'(bus0.host_ack),   int'(m_phase == L0 + 1 && m_owner));
                chk("owner",      int'(bus0.owner),      int'(m_owner));
                chk("cpu_rdata",  int'(bus0.cpu_rdata),  int'(m_cpu_rd));
                chk("host_rdata", int'(bus0.host_rdata), int'(m_host_rd));
                if (m_phase == 1) begin
                    chk("mem_addr", int'(bus0.mem_addr), int'(m_addr));
                    if (m_we) chk("mem_wdata", int'(bus0.mem_wdata), int'(m_wdata));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_ack(input bit host, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if ((host ? bus0.host_ack : bus0.cpu_ack) == 1'b1) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL ack_timeout: got no ack, required one within 20 cycles");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (!bus0.cpu_req && !bus0.host_req) break;
            tick();
            if (bus0.cpu_ack)  bus0.cpu_req  = 1'b0;
            if (bus0.host_ack) bus0.host_req = 1'b0;
        end
        chk("drain_done", int'(bus0.cpu_req | bus0.host_req), 0);
    endtask

    initial begin
        int cyc, ng, n_ack, n_en;
        bit got [10];
        bit pat [10];
        pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        reset = 1'b0;
        bus0.cpu_req = 1'b0; bus0.cpu_we = 1'b0; bus0.cpu_addr = 8'h00; bus0.cpu_wdata = 8'h00;
        bus0.host_req = 1'b0; bus0.host_we = 1'b0; bus0.host_addr = 8'h00; bus0.host_wdata = 8'h00;
        bus0.host_lock = 1'b0;
        bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = 8'h00; bus1.cpu_wdata = 8'h00;
        bus1.host_req = 1'b0; bus1.host_we = 1'b0; bus1.host_addr = 8'h00; bus1.host_wdata = 8'h00;
        bus1.host_lock = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst_mem_en", int'(bus0.mem_en), 0);
        chk("rst_mem_addr", int'(bus0.mem_addr), 0);
        chk("rst_mem_wdata", int'(bus0.mem_wdata), 0);
        chk("rst_busy", int'(bus0.busy), 0);
        chk("rst_rdata", int'({bus0.cpu_rdata, bus0.host_rdata}), 0);
        reset = 1'b1;
        tick();

        // CPU read of 0x10: mem_en in cycle 1, ack with A5 in cycle 2
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 8'h10;
        tick();
        chk("t1_mem_en_c1", int'(bus0.mem_en), 1);
        chk("t1_addr_c1", int'(bus0.mem_addr), 8'h10);
        tick();
        chk("t1_ack_c2", int'(bus0.cpu_ack), 1);
        chk("t1_rdata", int'(bus0.cpu_rdata), 8'hA5);
        bus0.cpu_req = 1'b0;
        tick();
        chk("t1_rdata_held", int'(bus0.cpu_rdata), 8'hA5);

        // Host write 3C to 0x20, then CPU reads it back
        bus0.host_req = 1'b1; bus0.host_we = 1'b1; bus0.host_addr = 8'h20; bus0.host_wdata = 8'h3C;
        wait_ack(1'b1, cyc);
        chk("t2_host_lat", cyc, L0 + 1);
        chk("t2_owner_host", int'(bus0.owner), 1);
        bus0.host_req = 1'b0;
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 8'h20;
        wait_ack(1'b0, cyc);
        chk("t2_rdata", int'(bus0.cpu_rdata), 8'h3C);
        chk("t2_owner_cpu", int'(bus0.owner), 0);
        bus0.cpu_req = 1'b0;
        tick();

        // Both held: host streak capped at HOST_MAX
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 8'h01;
        bus0.host_req = 1'b1; bus0.host_we = 1'b0; bus0.host_addr = 8'h02;
        ng = 0;
        for (int i = 0; i < 200 && ng < 10; i++) begin
            tick();
            if (bus0.mem_en) begin
                got[ng] = bus0.owner;
                ng++;
            end
        end
        chk("t3_grants", ng, 10);
        for (int k = 0; k < 10; k++) chk($sformatf("t3_grant%0d", k), int'(got[k]), int'(pat[k]));
        drain();

        // host_lock blocks the CPU; release grants it promptly
        bus0.host_lock = 1'b1;
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 8'h04;
        n_ack = 0; n_en = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_ack += int'(bus0.cpu_ack);
            n_en  += int'(bus0.mem_en);
        end
        chk("t4_locked_acks", n_ack, 0);
        chk("t4_locked_mem_en", n_en, 0);
        bus0.host_lock = 1'b0;
        wait_ack(1'b0, cyc);
        chk("t4_unlock_lat", cyc, L0 + 1);
        bus0.cpu_req = 1'b0;
        tick();

        // RD_LAT=3 host read on lane 1
        bus1.host_req = 1'b1; bus1.host_we = 1'b0; bus1.host_addr = 8'h33;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("t5_mem_en_c%0d", k), int'(bus1.mem_en), int'(k == 1));
            chk($sformatf("t5_ack_c%0d", k), int'(bus1.host_ack), int'(k == 4));
            chk($sformatf("t5_busy_c%0d", k), int'(bus1.busy), int'(k <= 4));
            if (k == 4) begin
                chk("t5_rdata", int'(bus1.host_rdata), 8'hCE);
                bus1.host_req = 1'b0;
            end
        end

        // Async reset during a host ACCESS
        bus0.host_req = 1'b1; bus0.host_we = 1'b0; bus0.host_addr = 8'h05;
        tick();
        chk("t6_in_access", int'(bus0.mem_en & bus0.owner), 1);
        #1 reset = 1'b0;
        #1;
        chk("t6_mem_en", int'(bus0.mem_en), 0);
        chk("t6_busy", int'(bus0.busy), 0);
        chk("t6_owner", int'(bus0.owner), 0);
        chk("t6_acks", int'(bus0.cpu_ack | bus0.host_ack), 0);
        bus0.host_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 8'h10;
        wait_ack(1'b0, cyc);
        chk("t6_after_lat", cyc, L0 + 1);
        chk("t6_after_rdata", int'(bus0.cpu_rdata), 8'hA5);
        bus0.cpu_req = 1'b0;
        tick();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!bus0.cpu_req || bus0.cpu_ack) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'($urandom_range(0, 1));
                    bus0.cpu_addr = 8'($urandom_range(0, 17)); bus0.cpu_wdata = 8'($urandom);
                end else begin
                    bus0.cpu_req = 1'b0;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                bus0.cpu_we = 1'($urandom_range(0, 1));
                bus0.cpu_addr = 8'($urandom_range(0, 17)); bus0.cpu_wdata = 8'($urandom);
            end
            if (!bus0.host_req || bus0.host_ack) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus0.host_req = 1'b1; bus0.host_we = 1'($urandom_range(0, 1));
                    bus0.host_addr = 8'($urandom_range(0, 17)); bus0.host_wdata = 8'($urandom);
                end else begin
                    bus0.host_req = 1'b0;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                bus0.host_we = 1'($urandom_range(0, 1));
                bus0.host_addr = 8'($urandom_range(0, 17)); bus0.host_wdata = 8'($urandom);
            end
            if ($urandom_range(0, 39) == 0) bus0.host_lock = ~bus0.host_lock;
        end
        bus0.host_lock = 1'b0;
        drain();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
